// File: rtl/bridge_pkg.sv
// ============================================================================
// bridge_pkg : shared state encoding, window defaults and decode helpers
// Revision   : 1.0
// ============================================================================
`default_nettype none

package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] c_t0_base      = 32'h00007f00;
  localparam logic [31:0] c_t1_base      = 32'h00007f10;
  localparam int unsigned c_win_bytes    = 12;
  localparam logic [31:0] c_unmapped_rd  = 32'h17230000;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] win);
    return (addr >= base) && ((addr - base) < win);
  endfunction

  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] t0,
                                      input logic [31:0] t1,
                                      input logic [31:0] win);
    return (addr[1:0] == 2'b00) && (in_window(addr, t0, win) || in_window(addr, t1, win));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bridge_arbiter_if.sv
// ============================================================================
// bridge_arbiter_if : two-master request/grant ports plus the bridge bus
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface bridge_arbiter_if;
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_gnt, m1_gnt;
  logic        m0_done, m1_done;
  logic        m0_err, m1_err;
  logic [31:0] rd;
  logic [31:0] addrbus;
  logic [31:0] wdbus;
  logic        we;
  logic [31:0] bridge_rd;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, bridge_rd,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, rd, addrbus, wdbus, we
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, bridge_rd,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, rd, addrbus, wdbus, we
  );
endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-requester round-robin picker with exclusion
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] excl,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  logic [1:0] w_elig;

  assign w_elig = req & ~excl;
  assign valid  = |w_elig;
  // On a tie the master not served last wins.
  assign winner = (w_elig == 2'b11) ? ~last : w_elig[1];

endmodule

`default_nettype wire

// File: rtl/bridge_arbiter.sv
// ============================================================================
// bridge_arbiter : two-master arbiter and access sequencer for the timer bridge
// Revision       : 1.0
// ============================================================================
`default_nettype none

module bridge_arbiter
  import bridge_pkg::*;
#(
  parameter logic [31:0] T0_BASE     = c_t0_base,
  parameter logic [31:0] T1_BASE     = c_t1_base,
  parameter int unsigned WIN_BYTES   = c_win_bytes,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  bridge_arbiter_if.slave  bus
);

  state_t      r_state;
  logic        r_last;
  logic [2:0]  r_cnt;
  logic        r_wr;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic [31:0] r_rd;
  logic [31:0] r_addrbus;
  logic [31:0] r_wdbus;
  logic        r_we;

  logic [1:0]  w_req;
  logic [1:0]  w_excl;
  logic [1:0]  w_gnt_nxt;
  logic        w_valid;
  logic        w_winner;
  logic        w_wr;
  logic        w_legal;
  logic [31:0] w_addr;
  logic [31:0] w_wd;

  assign w_req  = {bus.m1_req, bus.m0_req};
  // The master completing in RESP may still hold req, so it sits out this round.
  assign w_excl = (r_state == RESP) ? r_gnt : 2'b00;

  rr_arb2 u_arb (
    .req    (w_req),
    .excl   (w_excl),
    .last   (r_last),
    .valid  (w_valid),
    .winner (w_winner)
  );

  assign w_addr    = w_winner ? bus.m1_addr : bus.m0_addr;
  assign w_wd      = w_winner ? bus.m1_wd   : bus.m0_wd;
  assign w_wr      = w_winner ? bus.m1_we   : bus.m0_we;
  assign w_gnt_nxt = w_winner ? 2'b10 : 2'b01;
  assign w_legal   = addr_legal(w_addr, T0_BASE, T1_BASE, 32'(WIN_BYTES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= 3'd0;
      r_wr      <= 1'b0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_err     <= 2'b00;
      r_rd      <= 32'd0;
      r_addrbus <= 32'd0;
      r_wdbus   <= 32'd0;
      r_we      <= 1'b0;
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
      r_rd   <= 32'd0;
      r_we   <= 1'b0;
      case (r_state)
        ACCESS: begin
          if (r_cnt == 3'd0) begin
            r_state   <= RESP;
            r_done    <= r_gnt;
            r_rd      <= r_wr ? 32'd0 : bus.bridge_rd;
            r_addrbus <= 32'd0;
            r_wdbus   <= 32'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
            r_we  <= r_wr && (r_cnt == 3'd1);
          end
        end
        default: begin
          // IDLE and RESP share the grant path; RESP chains straight into the next owner.
          if (w_valid) begin
            r_last <= w_winner;
            r_wr   <= w_wr;
            r_gnt  <= w_gnt_nxt;
            if (w_legal) begin
              r_state   <= ACCESS;
              r_cnt     <= 3'(WAIT_STATES);
              r_addrbus <= w_addr;
              r_wdbus   <= w_wd;
              r_we      <= w_wr && (WAIT_STATES == 0);
            end else begin
              r_state   <= RESP;
              r_done    <= w_gnt_nxt;
              r_err     <= w_gnt_nxt;
              r_addrbus <= 32'd0;
              r_wdbus   <= 32'd0;
            end
          end else begin
            r_state   <= IDLE;
            r_gnt     <= 2'b00;
            r_addrbus <= 32'd0;
            r_wdbus   <= 32'd0;
          end
        end
      endcase
    end
  end

  assign bus.m0_gnt  = r_gnt[0];
  assign bus.m1_gnt  = r_gnt[1];
  assign bus.m0_done = r_done[0];
  assign bus.m1_done = r_done[1];
  assign bus.m0_err  = r_err[0];
  assign bus.m1_err  = r_err[1];
  assign bus.rd      = r_rd;
  assign bus.addrbus = r_addrbus;
  assign bus.wdbus   = r_wdbus;
  assign bus.we      = r_we;

endmodule

`default_nettype wire

// File: tb/tb_bridge_arbiter.sv
// ============================================================================
// tb_bridge_arbiter : three arbiters (WAIT_STATES 0/2/3) against a timeline model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_bridge_arbiter;
  import bridge_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][1:0]        t_req, t_we;
  logic [2:0][1:0][31:0]  t_addr, t_wd;
  logic [2:0][31:0]       t_brd;
  logic [2:0][1:0]        o_gnt, o_done, o_err;
  logic [2:0][31:0]       o_rd, o_ab, o_wdb;
  logic [2:0]             o_we;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    bridge_arbiter_if u_if ();
    assign u_if.m0_req    = t_req[g][0];
    assign u_if.m1_req    = t_req[g][1];
    assign u_if.m0_we     = t_we[g][0];
    assign u_if.m1_we     = t_we[g][1];
    assign u_if.m0_addr   = t_addr[g][0];
    assign u_if.m1_addr   = t_addr[g][1];
    assign u_if.m0_wd     = t_wd[g][0];
    assign u_if.m1_wd     = t_wd[g][1];
    assign u_if.bridge_rd = t_brd[g];
    assign o_gnt[g]  = {u_if.m1_gnt, u_if.m0_gnt};
    assign o_done[g] = {u_if.m1_done, u_if.m0_done};
    assign o_err[g]  = {u_if.m1_err, u_if.m0_err};
    assign o_rd[g]   = u_if.rd;
    assign o_ab[g]   = u_if.addrbus;
    assign o_wdb[g]  = u_if.wdbus;
    assign o_we[g]   = u_if.we;

    bridge_arbiter #(.WAIT_STATES(WS)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (u_if.slave)
    );
  end

  int n_vec, n_err, cyc, mode;
  // Reference model: one outstanding transaction per instance, described by its
  // owner, attributes and the cycle number of its completion pulse.
  bit          m_busy[3], m_legal[3], m_wr[3];
  int          m_last[3], m_own[3], m_tdone[3];
  logic [31:0] m_addr[3], m_wd[3], m_rdcap[3];
  int          we_exp[3], we_obs[3];
  bit          hold_once[3][2];

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  function automatic bit tb_legal(input logic [31:0] a);
    logic [1:0] lo;
    lo = a[1:0];
    return (lo == 2'b00) && ((a >= 32'h7f00 && a < 32'h7f0c) || (a >= 32'h7f10 && a < 32'h7f1c));
  endfunction

  function automatic logic [31:0] pick_addr();
    int unsigned k;
    k = $urandom_range(6);
    case (k)
      0, 1:    return 32'h7f00 + 32'(4 * $urandom_range(2));
      2, 3:    return 32'h7f10 + 32'(4 * $urandom_range(2));
      4:       return ($urandom_range(1) == 1) ? 32'h7f0c : 32'h7f1c;
      5:       return 32'h7f00 + 32'(16 * $urandom_range(1)) + 32'($urandom_range(3, 1));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_last[i] = 1;
      hold_once[i][0] = 1'b0;
      hold_once[i][1] = 1'b0;
    end
  endtask

  task automatic check_outputs(input int i);
    logic [1:0]  eg, ed, ee;
    logic [31:0] ea, ew, er;
    logic        ewe;
    bit          at_done, in_acc;
    eg = 2'b00; ed = 2'b00; ee = 2'b00; ea = '0; ew = '0; er = '0;
    at_done = m_busy[i] && (cyc == m_tdone[i]);
    in_acc  = m_busy[i] && m_legal[i] && (cyc < m_tdone[i]);
    if (m_busy[i]) eg = (m_own[i] == 1) ? 2'b10 : 2'b01;
    if (at_done) ed = eg;
    if (at_done && !m_legal[i]) ee = eg;
    ewe = in_acc && m_wr[i] && (cyc == m_tdone[i] - 1);
    if (in_acc) begin ea = m_addr[i]; ew = m_wd[i]; end
    if (at_done && m_legal[i] && !m_wr[i]) er = m_rdcap[i];
    chk($sformatf("gnt%0d", i), 32'(o_gnt[i]), 32'(eg));
    chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(ed));
    chk($sformatf("we%0d", i), 32'(o_we[i]), 32'(ewe));
    if (!m_busy[i] || at_done) chk($sformatf("err%0d", i), 32'(o_err[i]), 32'(ee));
    if (at_done) chk($sformatf("rd%0d", i), o_rd[i], er);
    if (!(at_done && m_legal[i])) begin
      chk($sformatf("addrbus%0d", i), o_ab[i], ea);
      chk($sformatf("wdbus%0d", i), o_wdb[i], ew);
    end
    if (o_we[i]) we_obs[i]++;
  endtask

  // Master agents decide the inputs seen at the edge that ends the current cycle.
  task automatic agents(input int i);
    bit done_now;
    for (int j = 0; j < 2; j++) begin
      done_now = m_busy[i] && (cyc == m_tdone[i]) && (m_own[i] == j);
      if (t_req[i][j]) begin
        if (done_now && mode != 1) begin
          if (hold_once[i][j]) hold_once[i][j] = 1'b0;
          else                 t_req[i][j] = 1'b0;
        end
      end else if (mode == 2 && $urandom_range(2) == 0) begin
        t_req[i][j]     = 1'b1;
        t_we[i][j]      = 1'($urandom_range(1));
        t_addr[i][j]    = pick_addr();
        t_wd[i][j]      = $urandom;
        hold_once[i][j] = ($urandom_range(3) == 0);
      end
    end
    if (mode == 2) t_brd[i] = $urandom;
  endtask

  task automatic model_adv(input int i);
    logic [1:0] r;
    int         w;
    if (m_busy[i] && m_legal[i] && cyc == m_tdone[i] - 1) begin
      if (m_wr[i]) we_exp[i]++;
      else         m_rdcap[i] = t_brd[i];
    end
    if (!m_busy[i] || cyc == m_tdone[i]) begin
      r = t_req[i];
      if (m_busy[i]) r[m_own[i]] = 1'b0;
      m_busy[i] = 1'b0;
      if (r != 2'b00) begin
        if (r == 2'b11) w = 1 - m_last[i];
        else            w = r[1] ? 1 : 0;
        m_busy[i]  = 1'b1;
        m_own[i]   = w;
        m_last[i]  = w;
        m_wr[i]    = t_we[i][w];
        m_addr[i]  = t_addr[i][w];
        m_wd[i]    = t_wd[i][w];
        m_legal[i] = tb_legal(m_addr[i]);
        m_tdone[i] = cyc + 1 + (m_legal[i] ? 1 + ws_of(i) : 0);
      end
    end
  endtask

  task automatic cycle_step();
    for (int i = 0; i < 3; i++) agents(i);
    for (int i = 0; i < 3; i++) model_adv(i);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_outputs(i);
  endtask

  task automatic set_req(input int j, input logic wr, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      t_req[i][j]  = 1'b1;
      t_we[i][j]   = wr;
      t_addr[i][j] = a;
      t_wd[i][j]   = d;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    t_req = '0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) check_outputs(i);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) check_outputs(i);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    n_vec = 0; n_err = 0; cyc = 0; mode = 0;
    t_req = '0; t_we = '0; t_addr = '0; t_wd = '0;
    for (int i = 0; i < 3; i++) begin
      t_brd[i] = c_unmapped_rd;
      we_exp[i] = 0;
      we_obs[i] = 0;
    end
    do_reset(3);

    // Both masters hammer the bus from reset: m0 takes the first tie, then alternation.
    mode = 1;
    set_req(0, 1'b0, 32'h00007f00, 32'h0);
    set_req(1, 1'b1, 32'h00007f14, 32'hcafe0001);
    repeat (30) cycle_step();
    mode = 0;
    repeat (15) cycle_step();

    for (int i = 0; i < 3; i++) t_brd[i] = 32'h0000abcd;
    set_req(0, 1'b0, 32'h00007f04, 32'h0);
    repeat (8) cycle_step();
    set_req(1, 1'b1, 32'h00007f10, 32'h12345678);
    repeat (8) cycle_step();
    set_req(0, 1'b0, 32'h00007f0c, 32'h0);
    repeat (4) cycle_step();
    set_req(0, 1'b1, 32'h00007f02, 32'h0000dead);
    repeat (4) cycle_step();
    set_req(0, 1'b1, 32'h00007f08, 32'h5a5a5a5a);
    for (int i = 0; i < 3; i++) hold_once[i][0] = 1'b1;
    repeat (14) cycle_step();

    mode = 2;
    repeat (500) cycle_step();
    mode = 0;
    repeat (25) cycle_step();

    // Abandon a WAIT_STATES=2 write in its second ACCESS cycle.
    set_req(1, 1'b1, 32'h00007f18, 32'h0badf00d);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      cycle_step();
      if (m_busy[1] && m_legal[1] && cyc == m_tdone[1] - 2) hit = 1'b1;
    end
    chk("rst_window", 32'(hit), 32'd1);
    #1;
    do_reset(2);

    t_brd[0] = 32'h13579bdf; t_brd[1] = 32'h13579bdf; t_brd[2] = 32'h13579bdf;
    set_req(1, 1'b0, 32'h00007f14, 32'h0);
    repeat (8) cycle_step();

    for (int i = 0; i < 3; i++) chk($sformatf("we_cnt%0d", i), 32'(we_obs[i]), 32'(we_exp[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
